// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
// Two-master / one-slave arbiter in front of the data-side memory map.
// M0 is the core load/store port, M1 a secondary master (boot loader, DMA).
// A grant FSM (IDLE, GNT0, GNT1) with round-robin priority issues one
// request/ready transaction at a time. The winner receives read data plus a
// one-cycle acknowledge.
//
// Ports
//   clk, rst                  clock and asynchronous active-high reset
//   mX_req/we/addr/wdata      master X request (held until ack), direction,
//                             byte address and write data
//   mX_ack/rdata/err          completion pulse, read data (held until the
//                             next ack to that master), timeout flag
//   m0_stall                  m0_req & ~m0_ack; freezes the core PC
//   s_we/s_re/s_addr/s_wdata  slave strobes and latched address/data
//   s_rdata/s_ready           slave read data and completion
//
// Build option ARB_TIMEOUT_EN: enables a per-grant wait counter. When it
// reaches TIMEOUT the transaction is abandoned and acked with err = 1 and
// rdata = 0. Without the option a grant waits forever and err is tied 0.
module mem_bus_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  m0_req,
    input  logic                  m0_we,
    input  logic [ADDR_WIDTH-1:0] m0_addr,
    input  logic [DATA_WIDTH-1:0] m0_wdata,
    output logic                  m0_ack,
    output logic [DATA_WIDTH-1:0] m0_rdata,
    output logic                  m0_err,
    output logic                  m0_stall,
    input  logic                  m1_req,
    input  logic                  m1_we,
    input  logic [ADDR_WIDTH-1:0] m1_addr,
    input  logic [DATA_WIDTH-1:0] m1_wdata,
    output logic                  m1_ack,
    output logic [DATA_WIDTH-1:0] m1_rdata,
    output logic                  m1_err,
    output logic                  s_we,
    output logic                  s_re,
    output logic [ADDR_WIDTH-1:0] s_addr,
    output logic [DATA_WIDTH-1:0] s_wdata,
    input  logic [DATA_WIDTH-1:0] s_rdata,
    input  logic                  s_ready
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic                  last_gnt_q, last_gnt_d;
    logic                  s_we_q, s_we_d;
    logic                  s_re_q, s_re_d;
    logic [ADDR_WIDTH-1:0] s_addr_q, s_addr_d;
    logic [DATA_WIDTH-1:0] s_wdata_q, s_wdata_d;
    logic                  m0_ack_q, m0_ack_d;
    logic                  m1_ack_q, m1_ack_d;
    logic [DATA_WIDTH-1:0] m0_rdata_q, m0_rdata_d;
    logic [DATA_WIDTH-1:0] m1_rdata_q, m1_rdata_d;

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             m0_err_q, m0_err_d;
    logic             m1_err_q, m1_err_d;
`endif

    // Next-state, grant latching and completion routing
    always_comb begin
        state_d    = state_q;
        last_gnt_d = last_gnt_q;
        s_we_d     = s_we_q;
        s_re_d     = s_re_q;
        s_addr_d   = s_addr_q;
        s_wdata_d  = s_wdata_q;
        m0_ack_d   = 1'b0;
        m1_ack_d   = 1'b0;
        m0_rdata_d = m0_rdata_q;
        m1_rdata_d = m1_rdata_q;
`ifdef ARB_TIMEOUT_EN
        cnt_d      = cnt_q;
        m0_err_d   = 1'b0;
        m1_err_d   = 1'b0;
`endif
        case (state_q)
            IDLE: begin
`ifdef ARB_TIMEOUT_EN
                cnt_d = {CNT_W{1'b0}};
`endif
                // On a contest, M0 wins unless it was the last master served.
                if (m0_req && (!m1_req || last_gnt_q)) begin
                    state_d    = GNT0;
                    last_gnt_d = 1'b0;
                    s_we_d     = m0_we;
                    s_re_d     = ~m0_we;
                    s_addr_d   = m0_addr;
                    s_wdata_d  = m0_wdata;
                end else if (m1_req) begin
                    state_d    = GNT1;
                    last_gnt_d = 1'b1;
                    s_we_d     = m1_we;
                    s_re_d     = ~m1_we;
                    s_addr_d   = m1_addr;
                    s_wdata_d  = m1_wdata;
                end else begin
                    state_d = IDLE;
                end
            end
            GNT0, GNT1: begin
                if (s_ready) begin
                    // A ready in the same cycle as the timeout limit completes normally.
                    state_d = IDLE;
                    s_we_d  = 1'b0;
                    s_re_d  = 1'b0;
                    if (state_q == GNT1) begin
                        m1_ack_d = 1'b1;
                        if (s_re_q) begin
                            m1_rdata_d = s_rdata;
                        end else begin
                            m1_rdata_d = m1_rdata_q;
                        end
                    end else begin
                        m0_ack_d = 1'b1;
                        if (s_re_q) begin
                            m0_rdata_d = s_rdata;
                        end else begin
                            m0_rdata_d = m0_rdata_q;
                        end
                    end
                end
`ifdef ARB_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT)) begin
                    state_d = IDLE;
                    s_we_d  = 1'b0;
                    s_re_d  = 1'b0;
                    if (state_q == GNT1) begin
                        m1_ack_d   = 1'b1;
                        m1_err_d   = 1'b1;
                        m1_rdata_d = {DATA_WIDTH{1'b0}};
                    end else begin
                        m0_ack_d   = 1'b1;
                        m0_err_d   = 1'b1;
                        m0_rdata_d = {DATA_WIDTH{1'b0}};
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`else
                else begin
                    state_d = state_q;
                end
`endif
            end
            default: begin
                state_d = IDLE;
                s_we_d  = 1'b0;
                s_re_d  = 1'b0;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            last_gnt_q <= 1'b1;
            s_we_q     <= 1'b0;
            s_re_q     <= 1'b0;
            s_addr_q   <= {ADDR_WIDTH{1'b0}};
            s_wdata_q  <= {DATA_WIDTH{1'b0}};
            m0_ack_q   <= 1'b0;
            m1_ack_q   <= 1'b0;
            m0_rdata_q <= {DATA_WIDTH{1'b0}};
            m1_rdata_q <= {DATA_WIDTH{1'b0}};
`ifdef ARB_TIMEOUT_EN
            cnt_q      <= {CNT_W{1'b0}};
            m0_err_q   <= 1'b0;
            m1_err_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            last_gnt_q <= last_gnt_d;
            s_we_q     <= s_we_d;
            s_re_q     <= s_re_d;
            s_addr_q   <= s_addr_d;
            s_wdata_q  <= s_wdata_d;
            m0_ack_q   <= m0_ack_d;
            m1_ack_q   <= m1_ack_d;
            m0_rdata_q <= m0_rdata_d;
            m1_rdata_q <= m1_rdata_d;
`ifdef ARB_TIMEOUT_EN
            cnt_q      <= cnt_d;
            m0_err_q   <= m0_err_d;
            m1_err_q   <= m1_err_d;
`endif
        end
    end

    assign s_we     = s_we_q;
    assign s_re     = s_re_q;
    assign s_addr   = s_addr_q;
    assign s_wdata  = s_wdata_q;
    assign m0_ack   = m0_ack_q;
    assign m1_ack   = m1_ack_q;
    assign m0_rdata = m0_rdata_q;
    assign m1_rdata = m1_rdata_q;
    assign m0_stall = m0_req & ~m0_ack_q;
`ifdef ARB_TIMEOUT_EN
    assign m0_err   = m0_err_q;
    assign m1_err   = m1_err_q;
`else
    assign m0_err   = 1'b0;
    assign m1_err   = 1'b0;
`endif

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed testbench for mem_bus_arbiter. Inputs change and outputs are
// sampled on the falling clock edge, so a "master" reacting to ack at the
// falling edge behaves like one that drops req combinationally on ack.
module tb_mem_bus_arbiter;

`ifdef ARB_TIMEOUT_EN
    localparam int TO = 4;
`else
    localparam int TO = 255;
`endif

    logic        clk;
    logic        rst;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic        m0_ack, m1_ack, m0_err, m1_err, m0_stall;
    logic [31:0] m0_rdata, m1_rdata;
    logic        s_we, s_re, s_ready;
    logic [31:0] s_addr, s_wdata, s_rdata;

    int checks;
    int errors;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    mem_bus_arbiter #(
        .DATA_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_ack(m0_ack), .m0_rdata(m0_rdata), .m0_err(m0_err), .m0_stall(m0_stall),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_ack(m1_ack), .m1_rdata(m1_rdata), .m1_err(m1_err),
        .s_we(s_we), .s_re(s_re), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_rdata(s_rdata), .s_ready(s_ready)
    );

    task automatic step();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        m0_req = 1'b0; m0_we = 1'b0; m0_addr = 32'h0; m0_wdata = 32'h0;
        m1_req = 1'b0; m1_we = 1'b0; m1_addr = 32'h0; m1_wdata = 32'h0;
        s_ready = 1'b0; s_rdata = 32'h0;
    endtask

    task automatic pulse_reset();
        idle_inputs();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        step();
        checks++;
        if ({m0_ack, m1_ack, m0_err, m1_err, s_we, s_re} !== 6'b0) begin
            errors++; $display("FAIL reset_ctrl got %b expected %b", {m0_ack, m1_ack, m0_err, m1_err, s_we, s_re}, 6'b0);
        end
        checks++;
        if ({s_addr, s_wdata} !== 64'h0) begin
            errors++; $display("FAIL reset_slave_bus got %h expected %h", {s_addr, s_wdata}, 64'h0);
        end
        checks++;
        if ({m0_rdata, m1_rdata} !== 64'h0) begin
            errors++; $display("FAIL reset_rdata got %h expected %h", {m0_rdata, m1_rdata}, 64'h0);
        end
        checks++;
        if (m0_stall !== 1'b0) begin
            errors++; $display("FAIL reset_stall got %b expected %b", m0_stall, 1'b0);
        end
        rst = 1'b0;
        // s_ready in IDLE must not produce anything
        s_ready = 1'b1;
        s_rdata = 32'hDEAD_BEEF;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if ({m0_ack, m1_ack, s_we, s_re} !== 4'b0) begin
                errors++; $display("FAIL idle_ready got %b expected %b", {m0_ack, m1_ack, s_we, s_re}, 4'b0);
            end
        end
        s_ready = 1'b0;
        s_rdata = 32'h0;
    endtask

    task automatic test_single_read();
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h1000_0004;
        #1;
        checks++;
        if (m0_stall !== 1'b1) begin
            errors++; $display("FAIL rd_stall_n got %b expected %b", m0_stall, 1'b1);
        end
        step();
        checks++;
        if ({s_re, s_we} !== 2'b10) begin
            errors++; $display("FAIL rd_strobe got %b expected %b", {s_re, s_we}, 2'b10);
        end
        checks++;
        if (s_addr !== 32'h1000_0004) begin
            errors++; $display("FAIL rd_addr got %h expected %h", s_addr, 32'h1000_0004);
        end
        checks++;
        if ({m0_stall, m0_ack} !== 2'b10) begin
            errors++; $display("FAIL rd_stall_n1 got %b expected %b", {m0_stall, m0_ack}, 2'b10);
        end
        s_ready = 1'b1;
        s_rdata = 32'hCAFE_0001;
        step();
        checks++;
        if ({m0_ack, m1_ack, m0_err, s_re} !== 4'b1000) begin
            errors++; $display("FAIL rd_ack got %b expected %b", {m0_ack, m1_ack, m0_err, s_re}, 4'b1000);
        end
        checks++;
        if (m0_rdata !== 32'hCAFE_0001) begin
            errors++; $display("FAIL rd_data got %h expected %h", m0_rdata, 32'hCAFE_0001);
        end
        checks++;
        if (m0_stall !== 1'b0) begin
            errors++; $display("FAIL rd_stall_ack got %b expected %b", m0_stall, 1'b0);
        end
        m0_req = 1'b0;
        s_ready = 1'b0;
        s_rdata = 32'h0;
        step();
        checks++;
        if ({m0_ack, s_re} !== 2'b00 || m0_rdata !== 32'hCAFE_0001) begin
            errors++; $display("FAIL rd_hold got ack/re %b data %h expected 00 %h", {m0_ack, s_re}, m0_rdata, 32'hCAFE_0001);
        end
    endtask

    task automatic test_contest();
        int ack0_cyc, ack1_cyc, n0, n1, nstb, dbl;
        logic [31:0] stb_addr [2];
        logic [31:0] stb_wdata [2];
        ack0_cyc = -1; ack1_cyc = -1; n0 = 0; n1 = 0; nstb = 0; dbl = 0;
        stb_addr[0] = 32'h0; stb_addr[1] = 32'h0; stb_wdata[0] = 32'h0; stb_wdata[1] = 32'h0;
        pulse_reset();
        m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h10; m0_wdata = 32'h55;
        m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h20; m1_wdata = 32'hAA;
        s_ready = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            step();
            if (m0_ack && m1_ack) dbl++;
            if (m0_ack) begin n0++; ack0_cyc = c; m0_req = 1'b0; end
            if (m1_ack) begin n1++; ack1_cyc = c; m1_req = 1'b0; end
            if (s_we || s_re) begin
                if (nstb < 2) begin
                    stb_addr[nstb] = s_addr;
                    stb_wdata[nstb] = s_wdata;
                end
                nstb++;
            end
        end
        s_ready = 1'b0;
        checks++;
        if (n0 !== 1 || n1 !== 1 || dbl !== 0) begin
            errors++; $display("FAIL contest_acks got m0 %0d m1 %0d dbl %0d expected 1 1 0", n0, n1, dbl);
        end
        checks++;
        if (ack0_cyc !== 2) begin
            errors++; $display("FAIL contest_first got cycle %0d expected %0d", ack0_cyc, 2);
        end
        checks++;
        if (ack1_cyc - ack0_cyc !== 2) begin
            errors++; $display("FAIL contest_spacing got %0d expected %0d", ack1_cyc - ack0_cyc, 2);
        end
        checks++;
        if (nstb !== 2) begin
            errors++; $display("FAIL contest_strobes got %0d expected %0d", nstb, 2);
        end
        checks++;
        if (stb_addr[0] !== 32'h10 || stb_addr[1] !== 32'h20) begin
            errors++; $display("FAIL contest_addr got %h %h expected %h %h", stb_addr[0], stb_addr[1], 32'h10, 32'h20);
        end
        checks++;
        if (stb_wdata[0] !== 32'h55 || stb_wdata[1] !== 32'hAA) begin
            errors++; $display("FAIL contest_wdata got %h %h expected %h %h", stb_wdata[0], stb_wdata[1], 32'h55, 32'hAA);
        end
    endtask

    task automatic test_alternate();
        int k0, k1, nstb, dbl;
        logic [31:0] exp_rd0, exp_rd1, exp_addr;
        k0 = 0; k1 = 0; nstb = 0; dbl = 0;
        exp_rd0 = 32'h0; exp_rd1 = 32'h0;
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h100;
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h200;
        s_ready = 1'b1;
        for (int c = 1; c <= 30; c++) begin
            step();
            s_rdata = 32'hD000_0000 | 32'(c);
            if (m0_ack && m1_ack) dbl++;
            if (m0_ack) begin
                checks++;
                if (m0_rdata !== exp_rd0) begin
                    errors++; $display("FAIL alt_rdata0 got %h expected %h", m0_rdata, exp_rd0);
                end
                k0++;
                m0_addr = 32'h100 + 32'(k0);
                if (k0 == 4) m0_req = 1'b0;
            end
            if (m1_ack) begin
                checks++;
                if (m1_rdata !== exp_rd1) begin
                    errors++; $display("FAIL alt_rdata1 got %h expected %h", m1_rdata, exp_rd1);
                end
                k1++;
                m1_addr = 32'h200 + 32'(k1);
                if (k1 == 4) m1_req = 1'b0;
            end
            if (s_re) begin
                exp_addr = (((nstb % 2) == 0) ? 32'h100 : 32'h200) + 32'(nstb / 2);
                checks++;
                if (s_addr !== exp_addr) begin
                    errors++; $display("FAIL alt_grant %0d got %h expected %h", nstb, s_addr, exp_addr);
                end
                if ((nstb % 2) == 0) exp_rd0 = s_rdata;
                else exp_rd1 = s_rdata;
                nstb++;
            end
        end
        s_ready = 1'b0;
        checks++;
        if (k0 !== 4 || k1 !== 4 || nstb !== 8 || dbl !== 0) begin
            errors++; $display("FAIL alt_totals got m0 %0d m1 %0d grants %0d dbl %0d expected 4 4 8 0", k0, k1, nstb, dbl);
        end
    endtask

    task automatic test_wait();
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h3000_0008; s_ready = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            step();
            if (c == 1) m1_addr = 32'hFFFF_FFFF;
            checks++;
            if ({s_re, s_we, m1_ack} !== 3'b100 || s_addr !== 32'h3000_0008) begin
                errors++; $display("FAIL wait_stable c%0d got re/we/ack %b addr %h expected 100 %h", c, {s_re, s_we, m1_ack}, s_addr, 32'h3000_0008);
            end
            if (c == 4) begin
                s_ready = 1'b1;
                s_rdata = 32'h1234_5678;
            end
        end
        step();
        checks++;
        if ({m1_ack, m0_ack, m1_err} !== 3'b100 || m1_rdata !== 32'h1234_5678) begin
            errors++; $display("FAIL wait_ack got ack/ack0/err %b data %h expected 100 %h", {m1_ack, m0_ack, m1_err}, m1_rdata, 32'h1234_5678);
        end
        m1_req = 1'b0; s_ready = 1'b0;
        step();
        // a write must not disturb held read data
        m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h40; m1_wdata = 32'h77;
        s_ready = 1'b1; s_rdata = 32'h0BAD_0BAD;
        step();
        checks++;
        if ({s_we, s_re} !== 2'b10 || s_wdata !== 32'h77) begin
            errors++; $display("FAIL wr_strobe got %b %h expected 10 %h", {s_we, s_re}, s_wdata, 32'h77);
        end
        step();
        checks++;
        if (m1_ack !== 1'b1 || m1_rdata !== 32'h1234_5678) begin
            errors++; $display("FAIL wr_keep got ack %b data %h expected 1 %h", m1_ack, m1_rdata, 32'h1234_5678);
        end
        m1_req = 1'b0; s_ready = 1'b0;
        step();
    endtask

    task automatic test_reset_mid();
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h100; m0_wdata = 32'h9; s_ready = 1'b0;
        step();
        checks++;
        if (s_re !== 1'b1) begin
            errors++; $display("FAIL rmid_gnt got %b expected %b", s_re, 1'b1);
        end
        rst = 1'b1;
        m0_req = 1'b0;
        #1;
        checks++;
        if ({s_we, s_re, m0_ack, m1_ack, m0_err, m1_err} !== 6'b0 || {s_addr, s_wdata} !== 64'h0) begin
            errors++; $display("FAIL rmid_clear got %b %h expected 0 0", {s_we, s_re, m0_ack, m1_ack, m0_err, m1_err}, {s_addr, s_wdata});
        end
        checks++;
        if ({m0_rdata, m1_rdata} !== 64'h0) begin
            errors++; $display("FAIL rmid_rdata got %h expected %h", {m0_rdata, m1_rdata}, 64'h0);
        end
        step();
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            step();
            checks++;
            if ({m0_ack, m1_ack, s_re, s_we} !== 4'b0) begin
                errors++; $display("FAIL rmid_noack got %b expected %b", {m0_ack, m1_ack, s_re, s_we}, 4'b0);
            end
        end
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h500;
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h600;
        step();
        checks++;
        if (s_re !== 1'b1 || s_addr !== 32'h500) begin
            errors++; $display("FAIL rmid_m0_first got re %b addr %h expected 1 %h", s_re, s_addr, 32'h500);
        end
        s_ready = 1'b1; s_rdata = 32'h5A5A_0001;
        step();
        checks++;
        if (m0_ack !== 1'b1 || m0_rdata !== 32'h5A5A_0001) begin
            errors++; $display("FAIL rmid_m0_ack got %b %h expected 1 %h", m0_ack, m0_rdata, 32'h5A5A_0001);
        end
        m0_req = 1'b0;
        s_rdata = 32'h6B6B_0002;
        step();
        step();
        checks++;
        if (m1_ack !== 1'b1 || m1_rdata !== 32'h6B6B_0002) begin
            errors++; $display("FAIL rmid_m1_ack got %b %h expected 1 %h", m1_ack, m1_rdata, 32'h6B6B_0002);
        end
        m1_req = 1'b0; s_ready = 1'b0;
        step();
    endtask

    task automatic test_timeout();
        int ack_cyc;
        ack_cyc = -1;
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h700; s_ready = 1'b0;
`ifdef ARB_TIMEOUT_EN
        for (int c = 1; c <= 10; c++) begin
            step();
            if (m0_ack) begin
                ack_cyc = c;
                checks++;
                if (m0_err !== 1'b1 || m0_rdata !== 32'h0) begin
                    errors++; $display("FAIL to_err got err %b data %h expected 1 %h", m0_err, m0_rdata, 32'h0);
                end
                m0_req = 1'b0;
                m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h800;
                break;
            end
        end
        checks++;
        if (ack_cyc !== 6) begin
            errors++; $display("FAIL to_latency got %0d expected %0d", ack_cyc, 6);
        end
        step();
        checks++;
        if (s_re !== 1'b1 || s_addr !== 32'h800) begin
            errors++; $display("FAIL to_next_m1 got re %b addr %h expected 1 %h", s_re, s_addr, 32'h800);
        end
        s_ready = 1'b1; s_rdata = 32'h1111_2222;
        step();
        checks++;
        if ({m1_ack, m1_err} !== 2'b10 || m1_rdata !== 32'h1111_2222) begin
            errors++; $display("FAIL to_m1_ack got %b %h expected 10 %h", {m1_ack, m1_err}, m1_rdata, 32'h1111_2222);
        end
        m1_req = 1'b0; s_ready = 1'b0;
        step();
        // ready arriving in the limit cycle completes normally
        m0_req = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            step();
            if (c == 5) begin s_ready = 1'b1; s_rdata = 32'h3333_4444; end
        end
        step();
        checks++;
        if ({m0_ack, m0_err} !== 2'b10 || m0_rdata !== 32'h3333_4444) begin
            errors++; $display("FAIL to_ready_wins got %b %h expected 10 %h", {m0_ack, m0_err}, m0_rdata, 32'h3333_4444);
        end
        m0_req = 1'b0; s_ready = 1'b0;
        step();
`else
        for (int c = 1; c <= 100; c++) begin
            step();
            if (m0_ack && ack_cyc < 0) ack_cyc = c;
        end
        checks++;
        if (ack_cyc !== -1 || m0_err !== 1'b0) begin
            errors++; $display("FAIL noto_ack got ack cycle %0d err %b expected -1 0", ack_cyc, m0_err);
        end
        checks++;
        if (s_re !== 1'b1 || s_addr !== 32'h700) begin
            errors++; $display("FAIL noto_hold got re %b addr %h expected 1 %h", s_re, s_addr, 32'h700);
        end
        s_ready = 1'b1; s_rdata = 32'h7777_0000;
        step();
        checks++;
        if ({m0_ack, m0_err} !== 2'b10 || m0_rdata !== 32'h7777_0000) begin
            errors++; $display("FAIL noto_late_ack got %b %h expected 10 %h", {m0_ack, m0_err}, m0_rdata, 32'h7777_0000);
        end
        m0_req = 1'b0; s_ready = 1'b0;
        step();
`endif
    endtask

    initial begin
        checks = 0;
        errors = 0;
        idle_inputs();
        rst = 1'b1;
        test_reset();
        test_single_read();
        test_contest();
        test_alternate();
        test_wait();
        test_reset_mid();
        test_timeout();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
